instruction_loader: RTL and testbench
=====================================

# instruction_loader

Boot-time writer for the CPU's instruction memory: accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words, and drives the instruction memory's write port at consecutive word addresses starting from 0. It holds the CPU in reset until the image is fully written. It sits between the host byte link (UART receiver or testbench) and the writable instruction memory, and is the write-side counterpart of the CPU's instruction fetch path.

## Interface
- DEPTH, 256: maximum image size in words; matches the 8-bit word index decoded from Address[9:2].
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request to reload; honoured only in DONE or ERR.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader can accept a byte this cycle.
- mem_we  output  1  instruction memory write enable, one-cycle pulse per word.
- mem_addr  output  32  byte address of the word being written, {22'b0, index[7:0], 2'b00}.
- mem_wdata  output  32  instruction word being written.
- cpu_hold  output  1  keep CPU in reset while high.
- done  output  1  image completely written (sticky).
- err  output  1  header word count exceeded DEPTH (sticky).
- words_written  output  9  number of words written in the current load.

## Operation
- States: LEN_HI, LEN_LO, DATA, WRITE, DONE, ERR. Reset state is LEN_HI.
- A byte is accepted on a rising edge with in_valid && in_ready. in_ready = 1 in LEN_HI, LEN_LO and DATA. in_ready = 0 in WRITE, DONE and ERR.
- Stream format:
  - 2-byte big-endian word count N.
  - Then 4*N bytes, big-endian per word: the first byte lands in [31:24].
- LEN_HI: accepted byte -> N[15:8]; go to LEN_LO.
- LEN_LO: accepted byte -> N[7:0].
  - Complete N == 0 -> DONE.
  - Complete N > DEPTH -> ERR.
  - Otherwise -> DATA with byte counter = 0 and index = 0.
- DATA: each accepted byte shifts into the word assembler and increments the byte counter (2 bits). The 4th byte goes to WRITE.
- WRITE (exactly one cycle):
  - mem_we = 1; mem_addr and mem_wdata hold the assembled word.
  - On exit, index and words_written increment.
  - Go to DONE if words_written + 1 == N, else DATA.
- DONE: done = 1, cpu_hold = 0.
- ERR: err = 1, cpu_hold = 0, no further writes.
- start in DONE or ERR:
  - Next state LEN_HI.
  - done, err, words_written, index and byte counter clear.
  - cpu_hold = 1.
- start in any other state is ignored.
- Bytes beyond 4*N are not accepted, because in_ready = 0 in DONE.
- The index never exceeds DEPTH-1, because N is checked before any write.

## Timing
- Reset values: in_ready 1, mem_we 0, mem_addr 0, mem_wdata 0, cpu_hold 1, done 0, err 0, words_written 0, state LEN_HI.
- All outputs except in_ready are registered. in_ready is decoded from the state register only; it has no combinational path from in_valid.
- Latency: mem_we asserts in the cycle immediately after the edge that accepted the 4th byte of a word. Peak throughput is 1 word per 5 cycles.
- mem_addr and mem_wdata are stable for the whole mem_we cycle. They hold their last values afterwards.
- Last word: done and cpu_hold = 0 take effect on the edge that ends the WRITE cycle of word N.
- N == 0: done = 1 on the edge after the LEN_LO byte is accepted.
- in_valid deasserted mid-word: the loader waits indefinitely with the partial word retained.
- Reset asserted mid-load:
  - Immediate return to reset values.
  - The partial word is discarded and no write is issued.
  - Words already in memory are not cleared.
- start coincident with reset: reset wins.

## Test plan
- Load 2 words: bytes 00 02 20 04 30 39 24 05 D4 31 -> mem_we pulses at addr 0x0 data 0x20043039, then addr 0x4 data 0x2405D431; then done = 1, cpu_hold = 0, words_written = 2.
- Header 00 00 -> no mem_we, done = 1 on the next edge, in_ready = 0.
- Header 01 01 (257 > DEPTH) -> err = 1, done = 0, no mem_we, cpu_hold = 0.
- Random in_valid gaps during a 12-word image -> identical writes at addresses 0x0 to 0x2C, each mem_we exactly one cycle with in_ready = 0 during it.
- Reset asserted after 2 data bytes of word 1 -> outputs return to reset values immediately; a reloaded 1-word image writes addr 0x0 correctly.
- start after DONE, then a new 1-word image 00 01 08 00 00 00 -> done clears and cpu_hold = 1 on start; write at addr 0x0 data 0x08000000; then done = 1 again.

Source files
------------

// File: rtl/instruction_loader_if.sv
// Byte-stream input, instruction-memory write port and load status of the boot loader.
interface instruction_loader_if;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        start;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        err;
    logic [8:0]  words_written;

    modport slave (
        input  in_data, in_valid, start,
        output in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, err, words_written
    );

    modport master (
        output in_data, in_valid, start,
        input  in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, err, words_written
    );
endinterface

// File: rtl/instruction_loader.sv
// Boot-time instruction memory writer: length-prefixed big-endian byte stream to
// consecutive word writes from address 0, holding the CPU in reset until complete.
module instruction_loader #(
    parameter int unsigned DEPTH = 256
) (
    input  logic                 clk,
    input  logic                 reset,
    instruction_loader_if.slave  bus
);
    localparam int unsigned IDX_W  = 8;
    localparam int unsigned CNT_W  = 9;
    localparam int unsigned LEN_W  = 16;
    localparam int unsigned WORD_W = 32;

    typedef enum logic [2:0] {LEN_HI, LEN_LO, DATA, WRITE, DONE, ERR} state_t;

    state_t             state, state_d;
    logic [LEN_W-1:0]   len, len_d;
    logic [1:0]         byte_cnt, byte_cnt_d;
    logic [23:0]        shift, shift_d;
    logic [IDX_W-1:0]   index, index_d;
    logic [CNT_W-1:0]   words_written, words_written_d;
    logic               mem_we, mem_we_d;
    logic [WORD_W-1:0]  mem_addr, mem_addr_d;
    logic [WORD_W-1:0]  mem_wdata, mem_wdata_d;
    logic               cpu_hold, cpu_hold_d;
    logic               done, done_d;
    logic               err, err_d;
    logic               accept;
    logic [LEN_W-1:0]   len_full;

    // Ready depends on state only, never on in_valid.
    assign bus.in_ready = (state == LEN_HI) || (state == LEN_LO) || (state == DATA);
    assign accept       = bus.in_valid && bus.in_ready;
    assign len_full     = {len[LEN_W-1:8], bus.in_data};

    assign bus.mem_we        = mem_we;
    assign bus.mem_addr      = mem_addr;
    assign bus.mem_wdata     = mem_wdata;
    assign bus.cpu_hold      = cpu_hold;
    assign bus.done          = done;
    assign bus.err           = err;
    assign bus.words_written = words_written;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= LEN_HI;
            len           <= '0;
            byte_cnt      <= '0;
            shift         <= '0;
            index         <= '0;
            words_written <= '0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            cpu_hold      <= 1'b1;
            done          <= 1'b0;
            err           <= 1'b0;
        end else begin
            state         <= state_d;
            len           <= len_d;
            byte_cnt      <= byte_cnt_d;
            shift         <= shift_d;
            index         <= index_d;
            words_written <= words_written_d;
            mem_we        <= mem_we_d;
            mem_addr      <= mem_addr_d;
            mem_wdata     <= mem_wdata_d;
            cpu_hold      <= cpu_hold_d;
            done          <= done_d;
            err           <= err_d;
        end
    end

    always_comb begin
        state_d         = state;
        len_d           = len;
        byte_cnt_d      = byte_cnt;
        shift_d         = shift;
        index_d         = index;
        words_written_d = words_written;
        mem_we_d        = 1'b0;
        mem_addr_d      = mem_addr;
        mem_wdata_d     = mem_wdata;
        cpu_hold_d      = cpu_hold;
        done_d          = done;
        err_d           = err;

        unique case (state)
            LEN_HI: begin
                if (accept) begin
                    len_d   = {bus.in_data, 8'h00};
                    state_d = LEN_LO;
                end
            end
            LEN_LO: begin
                if (accept) begin
                    len_d = len_full;
                    if (len_full == '0) begin
                        state_d    = DONE;
                        done_d     = 1'b1;
                        cpu_hold_d = 1'b0;
                    end else if (32'(len_full) > DEPTH) begin
                        state_d    = ERR;
                        err_d      = 1'b1;
                        cpu_hold_d = 1'b0;
                    end else begin
                        state_d    = DATA;
                        byte_cnt_d = '0;
                        index_d    = '0;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    shift_d    = {shift[15:0], bus.in_data};
                    byte_cnt_d = byte_cnt + 2'd1;
                    // Fourth byte completes the word; present it on the write port next cycle.
                    if (byte_cnt == 2'd3) begin
                        state_d     = WRITE;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = WORD_W'({index, 2'b00});
                        mem_wdata_d = {shift, bus.in_data};
                    end
                end
            end
            WRITE: begin
                index_d         = index + IDX_W'(1);
                words_written_d = words_written + CNT_W'(1);
                if (LEN_W'(words_written) + LEN_W'(1) == len) begin
                    state_d    = DONE;
                    done_d     = 1'b1;
                    cpu_hold_d = 1'b0;
                end else begin
                    state_d = DATA;
                end
            end
            DONE, ERR: begin
                if (bus.start) begin
                    state_d         = LEN_HI;
                    done_d          = 1'b0;
                    err_d           = 1'b0;
                    words_written_d = '0;
                    index_d         = '0;
                    byte_cnt_d      = '0;
                    cpu_hold_d      = 1'b1;
                end
            end
            default: state_d = LEN_HI;
        endcase
    end
endmodule

// File: tb/tb_instruction_loader.sv
// Self-checking bench for instruction_loader: vector table, randomized images against a
// queue-based model of the expected memory writes, and reset/start corner sequences.
module tb_instruction_loader;
    localparam int unsigned DEPTH = 256;

    logic clk;
    logic reset;

    instruction_loader_if bus();

    instruction_loader #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        string        name;
        int           nbytes;
        logic [127:0] bytes;
        logic         exp_done;
        logic         exp_err;
        int           exp_ww;
    } vec_t;

    int   checks;
    int   passed;
    int   writes_seen;
    wr_t  exp_q[$];
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Observes the write port every cycle and matches writes against the model queue.
    task automatic monitor();
        logic prev_we;
        wr_t  e;
        prev_we = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_we = 1'b0;
            end else begin
                if (bus.mem_we === 1'b1) begin
                    writes_seen++;
                    check("we_in_ready_low", 32'(bus.in_ready), 32'd0);
                    check("we_single_cycle", 32'(prev_we), 32'd0);
                    if (exp_q.size() == 0) begin
                        checks++;
                        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected",
                                 bus.mem_addr, bus.mem_wdata);
                    end else begin
                        e = exp_q.pop_front();
                        check("write_addr", bus.mem_addr, e.addr);
                        check("write_data", bus.mem_wdata, e.data);
                    end
                end
                prev_we = bus.mem_we;
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int gap;
        gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        bus.in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        for (int t = 0; t < 200; t++) begin
            if (bus.in_ready === 1'b1) begin
                @(posedge clk);
                @(negedge clk);
                bus.in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        checks++;
        $display("FAIL accept_timeout: byte 0x%0h not accepted within 200 cycles", b);
        bus.in_valid = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"},  32'(bus.in_ready), 32'd1);
        check({tag, "_mem_we"},    32'(bus.mem_we), 32'd0);
        check({tag, "_mem_addr"},  bus.mem_addr, 32'd0);
        check({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
        check({tag, "_cpu_hold"},  32'(bus.cpu_hold), 32'd1);
        check({tag, "_done"},      32'(bus.done), 32'd0);
        check({tag, "_err"},       32'(bus.err), 32'd0);
        check({tag, "_ww"},        32'(bus.words_written), 32'd0);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("start_done_clr", 32'(bus.done), 32'd0);
        check("start_err_clr",  32'(bus.err), 32'd0);
        check("start_hold",     32'(bus.cpu_hold), 32'd1);
        check("start_ww_clr",   32'(bus.words_written), 32'd0);
        check("start_ready",    32'(bus.in_ready), 32'd1);
    endtask

    // Model: header gives N; a legal N yields N writes of big-endian words at 4*i.
    task automatic run_stream(input string name, input logic [7:0] s[$], input int max_gap,
                              input logic exp_done, input logic exp_err, input int exp_ww);
        int n;
        int nexp;
        int base;
        int t;
        n    = int'({s[0], s[1]});
        nexp = (n >= 1 && n <= int'(DEPTH)) ? n : 0;
        for (int i = 0; i < nexp; i++)
            exp_q.push_back('{32'(4 * i), {s[2+4*i], s[3+4*i], s[4+4*i], s[5+4*i]}});
        base = writes_seen;
        foreach (s[k]) send_byte(s[k], max_gap);
        if (nexp > 0) begin
            check({name, "_done_during_last_we"}, 32'(bus.done), 32'd0);
            check({name, "_hold_during_last_we"}, 32'(bus.cpu_hold), 32'd1);
            @(negedge clk);
        end
        t = 0;
        while (!(bus.done || bus.err) && t < 20) begin
            @(negedge clk);
            t++;
        end
        check({name, "_done"},     32'(bus.done), 32'(exp_done));
        check({name, "_err"},      32'(bus.err), 32'(exp_err));
        check({name, "_cpu_hold"}, 32'(bus.cpu_hold), 32'd0);
        check({name, "_in_ready"}, 32'(bus.in_ready), 32'd0);
        check({name, "_ww"},       32'(bus.words_written), 32'(exp_ww));
        check({name, "_nwrites"},  32'(writes_seen - base), 32'(nexp));
        check({name, "_pending"},  32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] q[$];
        int n;

        checks      = 0;
        passed      = 0;
        writes_seen = 0;
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        reset        = 1'b1;

        fork
            monitor();
            begin
                #500000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "watchdog");
            end
        join_none

        vecs[0] = '{"two_word",   10, 128'h0002_2004_3039_2405_D431_0000_0000_0000, 1'b1, 1'b0, 2};
        vecs[1] = '{"empty",       2, 128'h0000_0000_0000_0000_0000_0000_0000_0000, 1'b1, 1'b0, 0};
        vecs[2] = '{"over_257",    2, 128'h0101_0000_0000_0000_0000_0000_0000_0000, 1'b0, 1'b1, 0};
        vecs[3] = '{"one_word",    6, 128'h0001_0800_0000_0000_0000_0000_0000_0000, 1'b1, 1'b0, 1};
        vecs[4] = '{"three_word", 14, 128'h0003_1111_2222_3333_4444_5555_6666_0000, 1'b1, 1'b0, 3};
        vecs[5] = '{"over_ffff",   2, 128'hFFFF_0000_0000_0000_0000_0000_0000_0000, 1'b0, 1'b1, 0};

        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        reset = 1'b0;
        @(negedge clk);
        check_reset_vals("idle");

        foreach (vecs[v]) begin
            if (v != 0) pulse_start();
            q.delete();
            for (int k = 0; k < vecs[v].nbytes; k++) q.push_back(vecs[v].bytes[127-8*k -: 8]);
            run_stream(vecs[v].name, q, 0, vecs[v].exp_done, vecs[v].exp_err, vecs[v].exp_ww);
        end

        // Randomized images with in_valid gaps, then a maximum-size image.
        for (int r = 0; r < 6; r++) begin
            n = (r == 0) ? 12 : (r == 5) ? int'(DEPTH) : int'($urandom_range(16, 1));
            pulse_start();
            q.delete();
            q.push_back(8'(n >> 8));
            q.push_back(8'(n));
            for (int k = 0; k < 4 * n; k++) q.push_back(8'($urandom));
            run_stream($sformatf("rand%0d", r), q, (r == 5) ? 0 : 3, 1'b1, 1'b0, n);
        end

        // Reset mid-word: partial word discarded, start during reset ignored.
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        reset = 1'b1;
        #1;
        check_reset_vals("midreset");
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check_reset_vals("after_reset");
        q.delete();
        q = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        run_stream("reload", q, 1, 1'b1, 1'b0, 1);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
